acq_search_ctrl: RTL and testbench

Acquisition and lock controller for the despreading receiver chain. It sequences the code-phase search by driving `shift_parse` into `m_code_31_generate` and `integrator`. Each code period it consumes the integrator's `result_ok`/`energy` dump, runs a full 31-phase sweep, slews the code back to the peak phase, confirms it, and then supervises lock. It replaces the free-running sliding control in the receiver top level.

---
 rtl/acq_pkg.sv | 33 +++
 rtl/acq_peak_tracker.sv | 39 +++
 rtl/acq_search_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_acq_search_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared state type, constants and modulo-CODE_LEN phase helpers for the
// code-phase acquisition controller.
package acq_pkg;

    localparam int CODE_LEN = 31;
    localparam int PHASE_W  = 5;
    localparam int ENERGY_W = 20;
    localparam int CNT_W    = 3;

    localparam logic [ENERGY_W-1:0] THRESH_DEF    = 20'd4096;
    localparam int                  CONFIRM_N_DEF = 3;
    localparam int                  LOSS_N_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_SLEW,
        ST_CONFIRM,
        ST_LOCKED
    } acq_state_t;

    // Next phase, wrapping from CODE_LEN-1 back to 0 (never through 31).
    function automatic logic [PHASE_W-1:0] mod_inc(input logic [PHASE_W-1:0] p);
        return (p >= PHASE_W'(CODE_LEN - 1)) ? '0 : p + PHASE_W'(1);
    endfunction

    // (a - b) mod CODE_LEN for a, b already in 0..CODE_LEN-1.
    function automatic logic [PHASE_W-1:0] mod_sub(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
        return (a >= b) ? a - b : PHASE_W'(CODE_LEN) - (b - a);
    endfunction

endpackage

// File: rtl/acq_peak_tracker.sv
// Running peak of the evaluated sweep dumps: remembers the largest energy and
// the absolute phase where it was seen. Strict compare keeps the earliest phase
// on ties. The cand outputs show the result including the current dump so the
// end-of-sweep decision can use the final value in the same cycle.
module acq_peak_tracker
    import acq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_update,
    input  logic [ENERGY_W-1:0] i_energy,
    input  logic [PHASE_W-1:0]  i_phase,
    output logic [PHASE_W-1:0]  o_best_phase,
    output logic [ENERGY_W-1:0] o_cand_max,
    output logic [PHASE_W-1:0]  o_cand_best
);

    logic [ENERGY_W-1:0] r_max_e;
    logic [PHASE_W-1:0]  r_best_phase;
    logic                w_greater;

    assign w_greater    = i_update && (i_energy > r_max_e);
    assign o_cand_max   = w_greater ? i_energy : r_max_e;
    assign o_cand_best  = w_greater ? i_phase  : r_best_phase;
    assign o_best_phase = r_best_phase;

    // Peak register: cleared at the start of every sweep, updated on a new maximum.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_max_e      <= '0;
            r_best_phase <= '0;
        end else if (w_greater) begin
            r_max_e      <= i_energy;
            r_best_phase <= i_phase;
        end
    end

endmodule

// File: rtl/acq_search_ctrl.sv
// Acquisition and lock controller: sweeps all code phases one chip at a time,
// slews back to the strongest phase, confirms it and then supervises lock.
module acq_search_ctrl
    import acq_pkg::*;
#(
    parameter logic [ENERGY_W-1:0] THRESH    = THRESH_DEF,
    parameter int                  CONFIRM_N = CONFIRM_N_DEF,
    parameter int                  LOSS_N    = LOSS_N_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                result_ok,
    input  logic [ENERGY_W-1:0] energy,
    output logic                shift_parse,
    output logic                busy,
    output logic                lock,
    output logic                fail,
    output logic [PHASE_W-1:0]  phase_idx,
    output logic [PHASE_W-1:0]  best_phase
);

    acq_state_t         r_state, w_state_next;
    logic [PHASE_W-1:0] r_phase, w_phase_next;
    logic [PHASE_W-1:0] r_sweep_cnt, w_sweep_cnt_next;
    logic [PHASE_W-1:0] r_slew_cnt, w_slew_cnt_next;
    logic [CNT_W-1:0]   r_conf_cnt, w_conf_cnt_next;
    logic [CNT_W-1:0]   r_loss_cnt, w_loss_cnt_next;
    logic               r_skip, w_skip_next;
    logic               r_gap, w_gap_next;
    logic               r_shift, w_shift_next;
    logic               r_fail, w_fail_next;
    logic               r_busy, w_busy_next;
    logic               r_lock, w_lock_next;
    logic               w_peak_clear;
    logic               w_peak_update;
    logic               w_hi;
    logic [ENERGY_W-1:0] w_cand_max;
    logic [PHASE_W-1:0]  w_cand_best;

    // A dump coincident with start is dropped: start always wins.
    assign w_peak_update = (r_state == ST_SWEEP) && result_ok && !start && !r_skip;
    assign w_hi          = (energy >= THRESH);

    acq_peak_tracker u_peak (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_peak_clear),
        .i_update     (w_peak_update),
        .i_energy     (energy),
        .i_phase      (r_phase),
        .o_best_phase (best_phase),
        .o_cand_max   (w_cand_max),
        .o_cand_best  (w_cand_best)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and datapath decisions; every dump-driven change lands on the following edge.
    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_sweep_cnt_next = r_sweep_cnt;
        w_slew_cnt_next  = r_slew_cnt;
        w_conf_cnt_next  = r_conf_cnt;
        w_loss_cnt_next  = r_loss_cnt;
        w_skip_next      = r_skip;
        w_gap_next       = r_gap;
        w_shift_next     = 1'b0;
        w_fail_next      = 1'b0;
        w_peak_clear     = 1'b0;
        if (start) begin
            w_state_next     = ST_SWEEP;
            w_phase_next     = '0;
            w_sweep_cnt_next = '0;
            w_slew_cnt_next  = '0;
            w_conf_cnt_next  = '0;
            w_loss_cnt_next  = '0;
            w_skip_next      = 1'b1;
            w_gap_next       = 1'b0;
            w_peak_clear     = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: ;
                ST_SWEEP: begin
                    if (result_ok) begin
                        if (r_skip) begin
                            w_skip_next = 1'b0;
                        end else if (r_sweep_cnt < PHASE_W'(CODE_LEN - 1)) begin
                            w_shift_next     = 1'b1;
                            w_phase_next     = mod_inc(r_phase);
                            w_sweep_cnt_next = r_sweep_cnt + PHASE_W'(1);
                            w_skip_next      = 1'b1;
                        end else if (w_cand_max < THRESH) begin
                            w_fail_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_slew_cnt_next = mod_sub(w_cand_best, r_phase);
                            w_gap_next      = 1'b0;
                            w_state_next    = ST_SLEW;
                        end
                    end
                end
                ST_SLEW: begin
                    if (r_slew_cnt == '0) begin
                        w_skip_next     = 1'b1;
                        w_conf_cnt_next = '0;
                        w_state_next    = ST_CONFIRM;
                    end else if (!r_gap) begin
                        w_shift_next    = 1'b1;
                        w_phase_next    = mod_inc(r_phase);
                        w_slew_cnt_next = r_slew_cnt - PHASE_W'(1);
                        w_gap_next      = 1'b1;
                    end else begin
                        w_gap_next = 1'b0;
                    end
                end
                ST_CONFIRM: begin
                    if (result_ok) begin
                        if (r_skip) begin
                            w_skip_next = 1'b0;
                        end else if (w_hi) begin
                            if (r_conf_cnt + CNT_W'(1) == CNT_W'(CONFIRM_N)) begin
                                w_loss_cnt_next = '0;
                                w_state_next    = ST_LOCKED;
                            end else begin
                                w_conf_cnt_next = r_conf_cnt + CNT_W'(1);
                            end
                        end else begin
                            w_sweep_cnt_next = '0;
                            w_skip_next      = 1'b1;
                            w_peak_clear     = 1'b1;
                            w_state_next     = ST_SWEEP;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (result_ok) begin
                        if (w_hi) begin
                            w_loss_cnt_next = '0;
                        end else if (r_loss_cnt + CNT_W'(1) == CNT_W'(LOSS_N)) begin
                            w_sweep_cnt_next = '0;
                            w_skip_next      = 1'b1;
                            w_peak_clear     = 1'b1;
                            w_state_next     = ST_SWEEP;
                        end else begin
                            w_loss_cnt_next = r_loss_cnt + CNT_W'(1);
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Status outputs follow the state being entered so they change on the same edge.
    always_comb begin
        w_busy_next = (w_state_next == ST_SWEEP) || (w_state_next == ST_SLEW) ||
                      (w_state_next == ST_CONFIRM);
        w_lock_next = (w_state_next == ST_LOCKED);
    end

    // Datapath counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_sweep_cnt <= '0;
            r_slew_cnt  <= '0;
            r_conf_cnt  <= '0;
            r_loss_cnt  <= '0;
            r_skip      <= 1'b0;
            r_gap       <= 1'b0;
            r_shift     <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_sweep_cnt <= w_sweep_cnt_next;
            r_slew_cnt  <= w_slew_cnt_next;
            r_conf_cnt  <= w_conf_cnt_next;
            r_loss_cnt  <= w_loss_cnt_next;
            r_skip      <= w_skip_next;
            r_gap       <= w_gap_next;
            r_shift     <= w_shift_next;
            r_fail      <= w_fail_next;
            r_busy      <= w_busy_next;
            r_lock      <= w_lock_next;
        end
    end

    assign shift_parse = r_shift;
    assign fail        = r_fail;
    assign busy        = r_busy;
    assign lock        = r_lock;
    assign phase_idx   = r_phase;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Self-checking bench for acq_search_ctrl: a behavioural model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_acq_search_ctrl;

    localparam int N  = 31;
    localparam int TH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        result_ok;
    logic [19:0] energy;
    logic        shift_parse, busy, lock, fail;
    logic [4:0]  phase_idx, best_phase;

    always #5 clk = ~clk;

    acq_search_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .result_ok   (result_ok),
        .energy      (energy),
        .shift_parse (shift_parse),
        .busy        (busy),
        .lock        (lock),
        .fail        (fail),
        .phase_idx   (phase_idx),
        .best_phase  (best_phase)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_shift = 0;
    int n_fail = 0;
    int lock_seen = 0;
    int e_tab[N];

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_SWEEP, M_SLEW, M_CONFIRM, M_LOCKED} mmode_t;
    mmode_t m_mode = M_IDLE;
    int  m_phase = 0, m_best = 0, m_start_ph = 0, m_n = 0;
    int  m_ev[N];
    bit  m_skip = 0;
    int  m_slew_left = 0;
    bit  m_slew_armed = 0;
    int  m_good = 0, m_bad = 0;
    bit  e_shift = 0, e_fail = 0;

    function automatic int peak_value();
        int v = 0;
        for (int k = 0; k < m_n; k++) if (m_ev[k] > v) v = m_ev[k];
        return v;
    endfunction

    function automatic int peak_phase();
        int v = 0, p = 0;
        for (int k = 0; k < m_n; k++)
            if (m_ev[k] > v) begin v = m_ev[k]; p = (m_start_ph + k) % N; end
        return p;
    endfunction

    task automatic begin_sweep();
        m_mode = M_SWEEP; m_start_ph = m_phase; m_n = 0; m_skip = 1; m_best = 0;
    endtask

    task automatic model_step();
        e_shift = 0; e_fail = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_phase = 0; m_best = 0; m_n = 0; m_skip = 0;
        end else if (start) begin
            m_phase = 0; begin_sweep();
        end else begin
            case (m_mode)
                M_SWEEP: if (result_ok) begin
                    if (m_skip) m_skip = 0;
                    else begin
                        m_ev[m_n] = int'(energy); m_n++; m_best = peak_phase();
                        if (m_n < N) begin
                            e_shift = 1; m_phase = (m_phase + 1) % N; m_skip = 1;
                        end else if (peak_value() < TH) begin
                            e_fail = 1; m_mode = M_IDLE;
                        end else begin
                            m_slew_left = ((m_best - m_phase) % N + N) % N;
                            m_slew_armed = 1; m_mode = M_SLEW;
                        end
                    end
                end
                M_SLEW: begin
                    if (m_slew_left == 0) begin
                        m_mode = M_CONFIRM; m_skip = 1; m_good = 0;
                    end else if (m_slew_armed) begin
                        e_shift = 1; m_phase = (m_phase + 1) % N;
                        m_slew_left--; m_slew_armed = 0;
                    end else m_slew_armed = 1;
                end
                M_CONFIRM: if (result_ok) begin
                    if (m_skip) m_skip = 0;
                    else if (int'(energy) >= TH) begin
                        m_good++;
                        if (m_good == 3) begin m_mode = M_LOCKED; m_bad = 0; end
                    end else begin_sweep();
                end
                M_LOCKED: if (result_ok) begin
                    if (int'(energy) >= TH) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_bad == 4) begin_sweep();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        logic [14:0] got, want;
        #1;
        model_step();
        got  = {shift_parse, busy, lock, fail, phase_idx, best_phase};
        want = {e_shift, (m_mode == M_SWEEP || m_mode == M_SLEW || m_mode == M_CONFIRM),
                (m_mode == M_LOCKED), e_fail, 5'(m_phase), 5'(m_best)};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got shift=%b busy=%b lock=%b fail=%b phase=%0d best=%0d, want shift=%b busy=%b lock=%b fail=%b phase=%0d best=%0d",
                     $time, got[14], got[13], got[12], got[11], got[9:5], got[4:0],
                     want[14], want[13], want[12], want[11], want[9:5], want[4:0]);
        end
        if (shift_parse === 1'b1) n_shift++;
        if (fail === 1'b1) n_fail++;
        if (lock === 1'b1) lock_seen = 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_tab(input int v);
        for (int k = 0; k < N; k++) e_tab[k] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic dump_e(input int v);
        repeat (2) @(negedge clk);
        result_ok = 1'b1;
        energy    = 20'(v);
        @(negedge clk);
        result_ok = 1'b0;
    endtask

    task automatic dump();
        dump_e(e_tab[m_phase]);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; result_ok = 1'b0; energy = '0;
        set_tab(100);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_phase", phase_idx, 0);
        rst_n = 1'b1;
        idle(2);

        // Peak at phase 17, then lock.
        set_tab(100); e_tab[17] = 9000;
        pulse_start();
        n_shift = 0;
        repeat (62) dump();
        chk("sweep_shifts", n_shift, 30);
        chk("best_17", best_phase, 17);
        chk("busy_in_slew", busy, 1);
        n_shift = 0;
        idle(40);
        chk("slew_shifts", n_shift, 18);
        chk("slew_phase", phase_idx, 17);
        repeat (3) dump();
        chk("lock_before_3rd_good", lock, 0);
        dump();
        chk("lock_after_confirm", lock, 1);

        // Lock loss: 3 low, 1 high, then 4 low.
        repeat (3) dump_e(100);
        dump_e(9000);
        repeat (3) dump_e(100);
        chk("lock_held", lock, 1);
        dump_e(100);
        chk("lock_lost", lock, 0);
        chk("busy_after_loss", busy, 1);

        // No peak: everything just below threshold.
        set_tab(4095);
        pulse_start();
        n_fail = 0;
        repeat (61) dump();
        chk("no_fail_early", n_fail, 0);
        dump();
        chk("fail_pulse", fail, 1);
        chk("fail_busy", busy, 0);
        chk("fail_lock", lock, 0);
        @(negedge clk);
        chk("fail_single", fail, 0);

        // Tie at phases 5 and 20.
        set_tab(100); e_tab[5] = 9000; e_tab[20] = 9000;
        pulse_start();
        repeat (62) dump();
        chk("tie_best", best_phase, 5);
        n_shift = 0;
        idle(20);
        chk("tie_slew", n_shift, 6);
        chk("tie_phase", phase_idx, 5);

        // Peak at phase 30: no slew needed.
        set_tab(100); e_tab[30] = 9000;
        pulse_start();
        repeat (62) dump();
        chk("best_30", best_phase, 30);
        n_shift = 0;
        idle(10);
        chk("no_slew", n_shift, 0);
        chk("phase_30", phase_idx, 30);
        chk("busy_confirm", busy, 1);

        // Confirm failure on the second counted dump.
        lock_seen = 0;
        dump(); dump(); dump_e(100);
        chk("confirm_fail_lock", lock_seen, 0);
        chk("confirm_fail_busy", busy, 1);
        n_shift = 0;
        dump();
        chk("resweep_skip", n_shift, 0);
        dump();
        chk("resweep_first", n_shift, 1);
        chk("resweep_phase", phase_idx, 0);
        chk("resweep_best", best_phase, 30);

        // Reset in the middle of SLEW.
        set_tab(100); e_tab[17] = 9000;
        pulse_start();
        repeat (62) dump();
        idle(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outputs", int'({shift_parse, busy, lock, fail, phase_idx, best_phase}), 0);
        rst_n = 1'b1;
        idle(2);

        // start coincident with result_ok mid-sweep.
        pulse_start();
        repeat (10) dump();
        chk("pre_restart_phase", phase_idx, 5);
        repeat (2) @(negedge clk);
        start = 1'b1; result_ok = 1'b1; energy = 20'd9000;
        @(negedge clk);
        start = 1'b0; result_ok = 1'b0;
        chk("restart_phase", phase_idx, 0);
        chk("restart_busy", busy, 1);
        n_shift = 0;
        dump();
        chk("restart_skip", n_shift, 0);
        dump();
        chk("restart_eval", n_shift, 1);
        chk("restart_phase1", phase_idx, 1);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
